// File: rtl/torreta_uc.sv
// Turret control unit: measure -> transmit -> evaluate -> (arm/fire/reload) -> wait -> rotate.
// Optional debug state output is enabled by defining TORRETA_UC_DB_ESTADO_EN.
module torreta_uc #(
  parameter int TIMEOUT_MEDIDA = 2_500_000,
  parameter int N_TIMEOUT      = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  input  logic       fim_tempo,
  input  logic       ameaca_detectada,
  input  logic       municao_carregada,
  input  logic       disparo_pronto,
  input  logic       fim_disparo,
  input  logic       disparo_carregado,
  output logic       zera,
  output logic       medir,
  output logic       transmitir,
  output logic       girar,
  output logic       conta_tempo,
  output logic       armar_disparo,
  output logic       disparar,
  output logic       recarregar_disparo,
  output logic       sem_municao,
`ifdef TORRETA_UC_DB_ESTADO_EN
  output logic       erro_medida,
  output logic [3:0] db_estado
`else
  output logic       erro_medida
`endif
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_ENVIO  = 4'd5,
    AVALIA         = 4'd6,
    ARMA           = 4'd7,
    DISPARA        = 4'd8,
    RECARREGA      = 4'd9,
    ESPERA         = 4'd10,
    GIRA           = 4'd11
  } estado_t;

  localparam logic [N_TIMEOUT-1:0] LIMITE = N_TIMEOUT'(TIMEOUT_MEDIDA - 1);

  estado_t              estado;
  estado_t              estado_next;
  logic [N_TIMEOUT-1:0] cnt_timeout;
  logic [N_TIMEOUT-1:0] cnt_inc;
  logic                 estouro;

  // Timeout fires on the cycle whose increment lands on the limit, so erro_medida
  // appears TIMEOUT_MEDIDA cycles after the medir pulse.
  assign cnt_inc = cnt_timeout + N_TIMEOUT'(1);
  assign estouro = (cnt_inc == LIMITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado;
    unique case (estado)
      INICIAL:        if (ligar) estado_next = PREPARA;
      PREPARA:        estado_next = MEDE;
      MEDE:           estado_next = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        if (medida_pronto)  estado_next = TRANSMITE;
        else if (estouro)   estado_next = ESPERA;
      end
      TRANSMITE:      estado_next = AGUARDA_ENVIO;
      AGUARDA_ENVIO:  if (envio_pronto) estado_next = AVALIA;
      AVALIA: begin
        if (ameaca_detectada && municao_carregada) estado_next = ARMA;
        else                                       estado_next = ESPERA;
      end
      ARMA:           if (disparo_pronto) estado_next = DISPARA;
      DISPARA:        if (fim_disparo) estado_next = RECARREGA;
      RECARREGA:      if (disparo_carregado) estado_next = ESPERA;
      ESPERA:         if (fim_tempo) estado_next = ligar ? GIRA : INICIAL;
      GIRA:           estado_next = MEDE;
      default:        estado_next = INICIAL;
    endcase
  end

  // Timeout counter and the two registered flags (still state-driven, no input-to-output path)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_timeout <= '0;
      erro_medida <= 1'b0;
      sem_municao <= 1'b0;
    end else begin
      if (estado == PREPARA || estado == MEDE) begin
        cnt_timeout <= '0;
      end else if (estado == AGUARDA_MEDIDA) begin
        cnt_timeout <= cnt_inc;
      end
      erro_medida <= (estado == AGUARDA_MEDIDA) && !medida_pronto && estouro;
      if (estado_next == PREPARA) begin
        sem_municao <= 1'b0;
      end else if (estado == AVALIA && ameaca_detectada && !municao_carregada) begin
        sem_municao <= 1'b1;
      end
    end
  end

  always_comb begin
    zera               = (estado == PREPARA);
    medir              = (estado == MEDE);
    transmitir         = (estado == TRANSMITE);
    girar              = (estado == GIRA);
    conta_tempo        = (estado == ESPERA);
    armar_disparo      = (estado == ARMA);
    disparar           = (estado == DISPARA);
    recarregar_disparo = (estado == RECARREGA);
  end

`ifdef TORRETA_UC_DB_ESTADO_EN
  assign db_estado = estado;
`endif

endmodule

// File: doc/torreta_uc.md
TORRETA_UC -- requirements
Module: torreta_uc

Interface
REQ-001 Parameter TIMEOUT_MEDIDA, default 2_500_000: cycles allowed between the medir pulse and medida_pronto (50 ms at 50 MHz).
REQ-002 Parameter N_TIMEOUT, default 22: width of the internal timeout counter.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ligar  input  1  level; 1 = run scan cycles, 0 = return to idle at the next cycle boundary.
REQ-006 medida_pronto, envio_pronto, fim_tempo  input  1 each  datapath status: measurement done, serial frame sent, inter-step timer expired.
REQ-007 ameaca_detectada, municao_carregada  input  1 each  threat registered; ammunition count > 0.
REQ-008 disparo_pronto, fim_disparo, disparo_carregado  input  1 each  arm, fire and reload phase complete.
REQ-009 zera  output  1  one-cycle synchronous clear to the datapath.
REQ-010 medir, transmitir, girar  output  1 each  one-cycle command pulses.
REQ-011 conta_tempo, armar_disparo, disparar, recarregar_disparo  output  1 each  levels, held for the whole phase.
REQ-012 sem_municao  output  1  sticky flag: a threat was seen with no ammunition.
REQ-013 erro_medida  output  1  one-cycle pulse on measurement timeout.

Function
REQ-014 States: INICIAL, PREPARA, MEDE, AGUARDA_MEDIDA, TRANSMITE, AGUARDA_ENVIO, AVALIA, ARMA, DISPARA, RECARREGA, ESPERA, GIRA.
REQ-015 INICIAL: all outputs 0 except sem_municao; go to PREPARA when ligar=1.
REQ-016 PREPARA: zera=1 for one cycle, sem_municao cleared, timeout counter cleared; then MEDE.
REQ-017 MEDE: medir=1 for one cycle, timeout counter cleared; then AGUARDA_MEDIDA.
REQ-018 AGUARDA_MEDIDA: timeout counter increments each cycle; medida_pronto=1 goes to TRANSMITE; if the count reaches TIMEOUT_MEDIDA-1 without medida_pronto, assert erro_medida for one cycle and go to ESPERA (no transmission). If medida_pronto and the timeout occur in the same cycle, medida_pronto wins.
REQ-019 TRANSMITE: transmitir=1 for one cycle; then AGUARDA_ENVIO, which waits for envio_pronto=1 and then goes to AVALIA.
REQ-020 AVALIA (one cycle): ameaca=1 & municao=1 goes to ARMA; ameaca=1 & municao=0 sets sem_municao and goes to ESPERA; ameaca=0 goes to ESPERA.
REQ-021 ARMA holds armar_disparo=1 until disparo_pronto=1, then goes to DISPARA.
REQ-022 DISPARA holds disparar=1 until fim_disparo=1, then goes to RECARREGA.
REQ-023 RECARREGA holds recarregar_disparo=1 until disparo_carregado=1, then goes to ESPERA.
REQ-024 ESPERA holds conta_tempo=1; on fim_tempo=1 it goes to GIRA if ligar=1, else to INICIAL.
REQ-025 GIRA: girar=1 for one cycle; then MEDE.
REQ-026 ligar=0 in any state other than ESPERA has no effect; a started engagement (ARMA..RECARREGA) always completes.
REQ-027 Status inputs are ignored outside the state that waits for them.
REQ-028 Exactly one of medir/transmitir/girar/zera is high in any cycle, or none.
REQ-029 Outputs are decoded from the state register only (Moore), with no combinational path from inputs to outputs.

Reset
REQ-030 reset=0 forces INICIAL immediately, regardless of clock: all outputs 0, sem_municao=0, timeout counter=0.
REQ-031 Reset asserted mid-engagement drops armar_disparo, disparar and recarregar_disparo asynchronously.
REQ-032 After reset is released, the first transition occurs on the next clock edge with ligar=1.

Configuration
REQ-033 Macro TORRETA_UC_DB_ESTADO_EN: when defined, add output db_estado [3:0], the current state encoded INICIAL=0 ... GIRA=11 in REQ-014 order (reset value 0).
REQ-034 When TORRETA_UC_DB_ESTADO_EN is undefined, the db_estado port and its logic are absent; all other behaviour is identical.

Verification
REQ-035 Reset release, ligar=1, medida_pronto 10 cycles after medir, ameaca=0, envio_pronto, fim_tempo -> sequence zera, medir, transmitir, conta_tempo, girar, then medir again.
REQ-036 ameaca=1, municao=1 -> armar_disparo high until disparo_pronto, then disparar until fim_disparo, then recarregar_disparo until disparo_carregado, then conta_tempo.
REQ-037 ameaca=1, municao=0 -> no fire outputs, sem_municao=1 and held; next PREPARA clears it.
REQ-038 TIMEOUT_MEDIDA=8, medida_pronto never asserted -> erro_medida pulses 8 cycles after medir, transmitir never asserted, controller enters ESPERA.
REQ-039 ligar dropped during DISPARA -> engagement completes, ESPERA, fim_tempo -> INICIAL with no girar pulse.
REQ-040 reset=0 while in RECARREGA -> recarregar_disparo=0 before the next clock edge; db_estado=0 when the macro is defined.
